cdb_arbiter_multi: RTL

Parametrised common-data-bus arbiter for the Tomasulo core: accepts completion results from NUM_SRC functional units (ALU(s), load/store buffer, future multiplier/branch units), grants at most one per cycle, and drives a single registered CDB broadcast to the ROB, reservation stations and LSB. It generalises the fixed two-source arbiter to N sources, adds round-robin fairness and flush squashing, and registers the broadcast.

---
 rtl/cdb_arbiter_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter_multi.sv
// Common-data-bus arbiter: grants one of NUM_SRC completing units per cycle and registers the broadcast.
// Define CDB_RR_ARB_EN for round-robin arbitration; otherwise the lowest index wins (fixed priority).
module cdb_arbiter_multi #(
    parameter int NUM_SRC  = 4,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*ROB_ID_W-1:0]  src_rob_id,
    input  logic [NUM_SRC*DATA_W-1:0]    src_value,
    input  logic [NUM_SRC*DATA_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]           src_outcome,
    output logic [NUM_SRC-1:0]           src_grant,
    output logic                         cdb_valid,
    output logic [ROB_ID_W-1:0]          cdb_rob_id,
    output logic [DATA_W-1:0]            cdb_value,
    output logic [DATA_W-1:0]            cdb_addr,
    output logic                         cdb_branch_outcome
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_any;

    logic               r_valid;
    logic [ROB_ID_W-1:0] r_rob_id;
    logic [DATA_W-1:0]  r_value;
    logic [DATA_W-1:0]  r_addr;
    logic               r_outcome;

    // Requests are invisible while in reset or flushing, so no grant can escape.
    assign w_req = (rst || flush) ? '0 : src_valid;

`ifdef CDB_RR_ARB_EN
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_next_ptr;

    always_comb begin
        int idx;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!w_any && w_req[idx]) begin
                w_any        = 1'b1;
                w_gidx       = PTR_W'(idx);
                w_grant[idx] = 1'b1;
            end
        end
    end

    // Explicit wrap keeps the pointer in range for non-power-of-two NUM_SRC.
    assign w_next_ptr = (w_gidx == PTR_W'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (w_any)
            r_rr_ptr <= w_next_ptr;
    end
`else
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_any && w_req[k]) begin
                w_any      = 1'b1;
                w_gidx     = PTR_W'(k);
                w_grant[k] = 1'b1;
            end
        end
    end
`endif

    // Data fields hold their last value when nothing is granted; only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_rob_id  <= '0;
            r_value   <= '0;
            r_addr    <= '0;
            r_outcome <= 1'b0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_rob_id  <= src_rob_id[int'(w_gidx)*ROB_ID_W +: ROB_ID_W];
                r_value   <= src_value[int'(w_gidx)*DATA_W +: DATA_W];
                r_addr    <= src_addr[int'(w_gidx)*DATA_W +: DATA_W];
                r_outcome <= src_outcome[w_gidx];
            end
        end
    end

    assign src_grant          = w_grant;
    assign cdb_valid          = r_valid;
    assign cdb_rob_id         = r_rob_id;
    assign cdb_value          = r_value;
    assign cdb_addr           = r_addr;
    assign cdb_branch_outcome = r_outcome;
endmodule
